// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
package fnd_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned BCD_DIGITS = 3;
   localparam int unsigned DD_W       = DATA_W + BCD_W * BCD_DIGITS;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 2;
   localparam int unsigned FONT_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } fnd_state_e;

   // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
   localparam logic [FONT_W-1:0] FONT_0     = 8'hC0;
   localparam logic [FONT_W-1:0] FONT_1     = 8'hF9;
   localparam logic [FONT_W-1:0] FONT_2     = 8'hA4;
   localparam logic [FONT_W-1:0] FONT_3     = 8'hB0;
   localparam logic [FONT_W-1:0] FONT_4     = 8'h99;
   localparam logic [FONT_W-1:0] FONT_5     = 8'h92;
   localparam logic [FONT_W-1:0] FONT_6     = 8'h82;
   localparam logic [FONT_W-1:0] FONT_7     = 8'hF8;
   localparam logic [FONT_W-1:0] FONT_8     = 8'h80;
   localparam logic [FONT_W-1:0] FONT_9     = 8'h90;
   localparam logic [FONT_W-1:0] FONT_BLANK = 8'hFF;

   // One double-dabble iteration on {hundreds, tens, ones, binary}.
   function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
      logic [DD_W-1:0] t;
      t = v;
      for (int d = 0; d < int'(BCD_DIGITS); d++) begin
         if (t[DATA_W + BCD_W * d +: BCD_W] >= 4'd5)
            t[DATA_W + BCD_W * d +: BCD_W] = t[DATA_W + BCD_W * d +: BCD_W] + 4'd3;
      end
      return {t[DD_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// BCD digit to active-low 7-segment font, with a forced-blank input.
module fnd_seg_decoder
   import fnd_pkg::*;
(
   input  logic [BCD_W-1:0]  i_bcd,
   input  logic              i_blank,
   output logic [FONT_W-1:0] o_font_c
);

   always_comb begin
      o_font_c = FONT_BLANK;
      if (!i_blank) begin
         case (i_bcd)
            4'd0:    o_font_c = FONT_0;
            4'd1:    o_font_c = FONT_1;
            4'd2:    o_font_c = FONT_2;
            4'd3:    o_font_c = FONT_3;
            4'd4:    o_font_c = FONT_4;
            4'd5:    o_font_c = FONT_5;
            4'd6:    o_font_c = FONT_6;
            4'd7:    o_font_c = FONT_7;
            4'd8:    o_font_c = FONT_8;
            4'd9:    o_font_c = FONT_9;
            default: o_font_c = FONT_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD converter driving a 4-digit multiplexed FND.
// Define FND_LZ_BLANK_EN to blank leading zeros on tens/hundreds.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100_000
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  load,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] fnd_com,
   output logic [FONT_W-1:0]     fnd_font
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DISP_W = BCD_W * BCD_DIGITS;

   fnd_state_e            r_state;
   fnd_state_e            w_state_next;
   logic                  w_capture;
   logic                  w_shift;
   logic                  w_commit;
   logic [2:0]            r_step;
   logic [DD_W-1:0]       r_dd;
   logic [DISP_W-1:0]     r_disp;
   logic [DISP_W-1:0]     w_disp_next;
   logic [CNT_W-1:0]      r_scan_cnt;
   logic                  w_wrap;
   logic [DIGIT_W-1:0]    r_digit;
   logic [DIGIT_W-1:0]    w_digit_next;
   logic [BCD_W-1:0]      w_sel_bcd;
   logic                  w_sel_blank;
   logic                  w_lz_tens;
   logic                  w_lz_hund;
   logic [FONT_W-1:0]     w_font;
   logic [NUM_DIGITS-1:0] w_com_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_capture    = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_step == 3'd7) w_state_next = ST_UPDATE;
         end
         ST_UPDATE: begin
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Conversion datapath; the display only picks up a finished result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dd   <= '0;
         r_step <= 3'd0;
         r_disp <= '0;
         busy   <= 1'b0;
      end else begin
         busy <= (w_state_next != ST_IDLE);
         if (w_capture) begin
            r_dd   <= {DISP_W'(0), data_in};
            r_step <= 3'd0;
         end else if (w_shift) begin
            r_dd   <= dd_step(r_dd);
            r_step <= r_step + 3'd1;
         end
         r_disp <= w_disp_next;
      end
   end

   assign w_disp_next  = w_commit ? r_dd[DD_W-1:DATA_W] : r_disp;
   assign w_wrap       = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_digit_next = w_wrap ? r_digit + DIGIT_W'(1) : r_digit;
   assign w_com_next   = ~(NUM_DIGITS'(1) << w_digit_next);

`ifdef FND_LZ_BLANK_EN
   assign w_lz_hund = (w_disp_next[2*BCD_W +: BCD_W] == 4'd0);
   assign w_lz_tens = w_lz_hund && (w_disp_next[BCD_W +: BCD_W] == 4'd0);
`else
   assign w_lz_hund = 1'b0;
   assign w_lz_tens = 1'b0;
`endif

   // Font is chosen from next-cycle digit/display so com and font move together.
   always_comb begin
      w_sel_bcd   = '0;
      w_sel_blank = 1'b0;
      case (w_digit_next)
         2'd0: w_sel_bcd = w_disp_next[0 +: BCD_W];
         2'd1: begin
            w_sel_bcd   = w_disp_next[BCD_W +: BCD_W];
            w_sel_blank = w_lz_tens;
         end
         2'd2: begin
            w_sel_bcd   = w_disp_next[2*BCD_W +: BCD_W];
            w_sel_blank = w_lz_hund;
         end
         default: w_sel_blank = 1'b1;
      endcase
   end

   fnd_seg_decoder u_seg_decoder (
      .i_bcd    (w_sel_bcd),
      .i_blank  (w_sel_blank),
      .o_font_c (w_font)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_scan_cnt <= '0;
         r_digit    <= '0;
         fnd_com    <= 4'b1110;
         fnd_font   <= FONT_0;
      end else begin
         r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + CNT_W'(1);
         r_digit    <= w_digit_next;
         fnd_com    <= w_com_next;
         fnd_font   <= w_font;
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized self-checking bench; SCAN_DIV=4 and SCAN_DIV=1 instances share stimulus.
module tb_fnd_scan_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       busy, busy1;
   logic [3:0] fnd_com, fnd_com1;
   logic [7:0] fnd_font, fnd_font1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_left = 0;
   int m_val = 0;
   int m_disp = 0;

   always #5 clk = ~clk;

   fnd_scan_controller #(.SCAN_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .busy(busy), .fnd_com(fnd_com), .fnd_font(fnd_font));

   fnd_scan_controller #(.SCAN_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .busy(busy1), .fnd_com(fnd_com1), .fnd_font(fnd_font1));

   // Reference: a load outside a conversion shows up on the display 9 edges later.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc <= 0; m_left <= 0; m_val <= 0; m_disp <= 0;
      end else begin
         cyc <= cyc + 1;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_disp <= m_val;
         end else if (load) begin
            m_val  <= int'(data_in);
            m_left <= 9;
         end
      end
   end

   function automatic logic [7:0] seg_of(int d);
      case (d)
         0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
         4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
         8: return 8'h80; 9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] exp_font(int val, int dig);
      int h, t, o;
      logic [7:0] f;
      h = val / 100; t = (val / 10) % 10; o = val % 10;
      case (dig)
         0: f = seg_of(o);
         1: begin
            f = seg_of(t);
`ifdef FND_LZ_BLANK_EN
            if (h == 0 && t == 0) f = 8'hFF;
`endif
         end
         2: begin
            f = seg_of(h);
`ifdef FND_LZ_BLANK_EN
            if (h == 0) f = 8'hFF;
`endif
         end
         default: f = 8'hFF;
      endcase
      return f;
   endfunction

   function automatic logic [3:0] exp_com(int dig);
      case (dig)
         0: return 4'b1110; 1: return 4'b1101; 2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic drive_load(input logic [7:0] v);
      @(negedge clk);
      data_in = v;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL reset_com: got %b expected 1110", fnd_com); end
      checks++; if (fnd_font !== 8'hC0) begin errors++; $display("FAIL reset_font: got %h expected C0", fnd_font); end
      checks++; if (fnd_com1 !== 4'b1110) begin errors++; $display("FAIL reset_com1: got %b expected 1110", fnd_com1); end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (fnd_com !== exp_com((cyc / 4) % 4)) begin errors++; $display("FAIL scan_com cyc=%0d: got %b expected %b", cyc, fnd_com, exp_com((cyc / 4) % 4)); end
         checks++; if (fnd_font !== exp_font(0, (cyc / 4) % 4)) begin errors++; $display("FAIL scan_font cyc=%0d: got %h expected %h", cyc, fnd_font, exp_font(0, (cyc / 4) % 4)); end
         checks++; if (fnd_com1 !== exp_com(cyc % 4)) begin errors++; $display("FAIL scan1_com cyc=%0d: got %b expected %b", cyc, fnd_com1, exp_com(cyc % 4)); end
      end
   endtask

   task automatic test_busy_window();
      int n;
      drive_load(8'd9);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b1) break;
         n++;
         @(negedge clk);
      end
      checks++; if (n != 9) begin errors++; $display("FAIL busy_len: got %0d expected 9", n); end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (fnd_com == 4'b1110) begin
            checks++; if (fnd_font !== 8'h90) begin errors++; $display("FAIL ones_9: got %h expected 90", fnd_font); end
         end
      end
   endtask

   task automatic test_digits_255();
      logic [7:0] want;
      drive_load(8'd255);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         case (fnd_com)
            4'b1110: want = 8'h92;
            4'b1101: want = 8'h92;
            4'b1011: want = 8'hA4;
            default: want = 8'hFF;
         endcase
         checks++; if (fnd_com !== exp_com((cyc / 4) % 4)) begin errors++; $display("FAIL d255_com: got %b expected %b", fnd_com, exp_com((cyc / 4) % 4)); end
         checks++; if (fnd_font !== want) begin errors++; $display("FAIL d255_font com=%b: got %h expected %h", fnd_com, fnd_font, want); end
      end
   endtask

   task automatic test_ignore_busy();
      drive_load(8'd100);
      @(negedge clk);
      data_in = 8'd7;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++; if (busy !== (m_left > 0)) begin errors++; $display("FAIL ign_busy cyc=%0d: got %b expected %b", cyc, busy, m_left > 0); end
         checks++; if (fnd_font !== exp_font(m_disp, (cyc / 4) % 4)) begin errors++; $display("FAIL ign_font cyc=%0d: got %h expected %h", cyc, fnd_font, exp_font(m_disp, (cyc / 4) % 4)); end
         if (fnd_com == 4'b1011) begin
            checks++; if (fnd_font !== 8'hF9) begin errors++; $display("FAIL ign_hund: got %h expected F9", fnd_font); end
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [7:0] want_lz;
`ifdef FND_LZ_BLANK_EN
      want_lz = 8'hFF;
`else
      want_lz = 8'hC0;
`endif
      drive_load(8'd5);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (fnd_com == 4'b1101 || fnd_com == 4'b1011) begin
            checks++; if (fnd_font !== want_lz) begin errors++; $display("FAIL lz com=%b: got %h expected %h", fnd_com, fnd_font, want_lz); end
         end else if (fnd_com == 4'b1110) begin
            checks++; if (fnd_font !== 8'h92) begin errors++; $display("FAIL lz_ones: got %h expected 92", fnd_font); end
         end
      end
   endtask

   task automatic test_reset_abort();
      drive_load(8'd200);
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (fnd_font !== 8'hC0 || fnd_com !== 4'b1110) begin errors++; $display("FAIL abort_out: got %b/%h expected 1110/C0", fnd_com, fnd_font); end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle cyc=%0d: got %b expected 0", cyc, busy); end
         checks++; if (fnd_font !== exp_font(0, (cyc / 4) % 4)) begin errors++; $display("FAIL abort_font cyc=%0d: got %h expected %h", cyc, fnd_font, exp_font(0, (cyc / 4) % 4)); end
         checks++; if (fnd_com1 !== exp_com(cyc % 4)) begin errors++; $display("FAIL abort_com1 cyc=%0d: got %b expected %b", cyc, fnd_com1, exp_com(cyc % 4)); end
      end
      // Load presented right at release must be taken on the first edge.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      data_in = 8'd37;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_load: got %b expected 1", busy); end
      repeat (9) @(negedge clk);
      checks++; if (fnd_font !== exp_font(37, (cyc / 4) % 4)) begin errors++; $display("FAIL first_val: got %h expected %h", fnd_font, exp_font(37, (cyc / 4) % 4)); end
   endtask

   task automatic test_random();
      int gap;
      for (int n = 0; n < 30; n++) begin
         drive_load(8'($urandom_range(0, 255)));
         gap = int'($urandom_range(0, 14));
         for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            checks++; if (busy !== (m_left > 0) || busy1 !== (m_left > 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d: got %b/%b expected %b", cyc, busy, busy1, m_left > 0); end
            checks++; if (fnd_com !== exp_com((cyc / 4) % 4) || fnd_font !== exp_font(m_disp, (cyc / 4) % 4)) begin
               errors++; $display("FAIL rnd_out cyc=%0d: got %b/%h expected %b/%h", cyc, fnd_com, fnd_font, exp_com((cyc / 4) % 4), exp_font(m_disp, (cyc / 4) % 4));
            end
            checks++; if (fnd_com1 !== exp_com(cyc % 4) || fnd_font1 !== exp_font(m_disp, cyc % 4)) begin
               errors++; $display("FAIL rnd_out1 cyc=%0d: got %b/%h expected %b/%h", cyc, fnd_com1, fnd_font1, exp_com(cyc % 4), exp_font(m_disp, cyc % 4));
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_busy_window();
      test_digits_255();
      test_ignore_busy();
      test_leading_zero();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000, meaning the number of clk cycles each digit is driven (minimum 1).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port data_in, input, 8 bits: unsigned value to display (0..255).
REQ-005 SHALL have port load, input, 1 bit: single-cycle strobe that qualifies data_in.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port fnd_com, output, 4 bits: active-low one-hot digit enable (bit 0 = ones digit).
REQ-008 SHALL have port fnd_font, output, 8 bits: active-low segments for the currently enabled digit, bit 7 = dp (always 1).

Function
REQ-009 SHALL implement an FSM with states IDLE, SHIFT and UPDATE.
REQ-010 In IDLE, load=1 at edge k SHALL capture data_in and enter SHIFT at edge k.
REQ-011 SHIFT SHALL perform one sequential double-dabble step per cycle for exactly 8 cycles (edges k+1..k+8), then enter UPDATE.
REQ-012 UPDATE SHALL commit the hundreds/tens/ones BCD result to the display registers at edge k+9 and return to IDLE.
REQ-013 busy SHALL be 1 exactly in SHIFT and UPDATE (9 cycles per load).
REQ-014 load while busy=1 SHALL be ignored; the conversion in progress and the display are unaffected.
REQ-015 The display registers SHALL change only in UPDATE, so a partially converted value is never shown.
REQ-016 The scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
REQ-017 On each wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-018 With SCAN_DIV=1, the digit index SHALL advance every cycle.
REQ-019 fnd_com SHALL be 1110, 1101, 1011, 0111 for digit index 0, 1, 2, 3 respectively.
REQ-020 Digit index 0, 1, 2 SHALL show ones, tens and hundreds respectively; digit 3 SHALL always be blank (fnd_font=FF).
REQ-021 The font SHALL be:
- 0=C0, 1=F9, 2=A4, 3=B0, 4=99
- 5=92, 6=82, 7=F8, 8=80, 9=90
- blank=FF
REQ-022 fnd_com and fnd_font SHALL be registered outputs that always change on the same edge.

Reset
REQ-023 While reset=0, all of the following SHALL hold:
- state IDLE; busy 0
- scan counter and digit index 0
- BCD and display registers 0
- fnd_com=1110, fnd_font=C0
REQ-024 Reset asserted mid-conversion SHALL abort the conversion; after release, the block is in IDLE showing 0.
REQ-025 Reset release SHALL need no synchronisation inside this block; the first load is accepted on the first edge after release.

Configuration
REQ-026 Macro FND_LZ_BLANK_EN SHALL select leading-zero blanking.
REQ-027 With FND_LZ_BLANK_EN defined:
- hundreds=0 -> hundreds digit shows FF
- hundreds=0 and tens=0 -> tens digit shows FF
- the ones digit is always shown
REQ-028 Without FND_LZ_BLANK_EN, leading zeros SHALL be displayed as C0.

Structure
REQ-029 Package fnd_pkg SHALL hold:
- the FSM state typedef
- the font constants for 0..9
- the FONT_BLANK constant
- the digit-count constant (4)
REQ-030 Combinational sub-module fnd_seg_decoder (4-bit BCD plus blank flag -> 8-bit font) SHALL be the only sub-module.

Verification (SCAN_DIV=4 unless noted)
REQ-031 Scenario: hold reset=0, then release -> fnd_com=1110, fnd_font=C0, busy=0; digit index advances every 4 cycles.
REQ-032 Scenario: load data_in=9 -> busy high for 9 cycles; then ones digit shows 90.
REQ-033 Scenario: load data_in=255 -> digits 0/1/2/3 show 92/92/A4/FF with fnd_com 1110/1101/1011/0111.
REQ-034 Scenario: load 100, then load 7 two cycles later -> 7 is ignored; display ends as ones=C0, tens=C0, hundreds=F9.
REQ-035 Scenario: load 5 -> with FND_LZ_BLANK_EN, tens and hundreds show FF; without it, they show C0.
REQ-036 Scenario: load 200, then reset=0 at cycle 4 of SHIFT -> busy=0 and display 0 after release; SCAN_DIV=1 run shows fnd_com rotating every cycle.
